// File: rtl/ysyx_22050598_pipe_ctrl.sv
// ysyx_22050598_pipe_ctrl: hazard/pipeline stall-flush controller; optional perf counters under YSYX_22050598_HAZ_PERF_EN
module ysyx_22050598_pipe_ctrl #(
  parameter int FENCEI_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_idx,
  input  logic [4:0] id_rs2_idx,
  input  logic       id_rs1_ren,
  input  logic       id_rs2_ren,
  input  logic [4:0] ex_rd_idx,
  input  logic       ex_w_reg_en,
  input  logic       ex_ls_req,
  input  logic       ex_is_store,
  input  logic       ex_redirect,
  input  logic       ex_muldiv_start,
  input  logic       muldiv_done,
  input  logic       mem_busy,
  input  logic       ex_is_fencei,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       fencei_redirect
`ifdef YSYX_22050598_HAZ_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] MULDIV_WAIT  = 2'd1;
  localparam logic [1:0] FENCEI_DRAIN = 2'd2;
  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             hazard;
  assign hazard = ex_ls_req & ~ex_is_store & ex_w_reg_en & (ex_rd_idx != 5'd0) &
                  ((id_rs1_ren & (id_rs1_idx == ex_rd_idx)) | (id_rs2_ren & (id_rs2_idx == ex_rd_idx)));
  always_comb begin
    {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, fencei_redirect} = '0;
    nxt_state = state;
    nxt_cnt   = cnt;
    if (rst) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else if (mem_busy) begin
      {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} = 4'hf;
    end else if (state == MULDIV_WAIT) begin
      if (muldiv_done) nxt_state = IDLE;
      else {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = 4'hf;
    end else if (state == FENCEI_DRAIN) begin
      {pc_stall, if_id_flush, id_ex_flush} = 3'b111;
      fencei_redirect = (cnt == '0);
      nxt_state = (cnt == '0) ? IDLE : FENCEI_DRAIN;
      nxt_cnt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    end else if (ex_redirect) begin
      {if_id_flush, id_ex_flush} = 2'b11;
    end else if (ex_is_fencei) begin
      {pc_stall, if_id_flush} = 2'b11;
      nxt_state = FENCEI_DRAIN;
      nxt_cnt   = CNT_W'(FENCEI_CYCLES - 1);
    end else if (ex_muldiv_start) begin
      if (!muldiv_done) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = 4'hf;
        nxt_state = MULDIV_WAIT;
      end
    end else if (hazard) begin
      {pc_stall, if_id_stall, id_ex_flush} = 3'b111;
    end
  end
  always_ff @(posedge clk) begin
    state <= nxt_state;
    cnt   <= nxt_cnt;
  end
`ifdef YSYX_22050598_HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, pc_stall};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, id_ex_flush};
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_22050598_pipe_ctrl.sv
// tb_ysyx_22050598_pipe_ctrl: scoreboard bench with directed and random stimulus against a behavioural model
module tb_ysyx_22050598_pipe_ctrl;
  localparam int FC = 4;
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       ren1, ren2;
    logic [4:0] rd;
    logic       wen, ls, st, redir, mds, mdd, busy, fi;
  } stim_t;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic id_rs1_ren, id_rs2_ren, ex_w_reg_en, ex_ls_req, ex_is_store, ex_redirect;
  logic ex_muldiv_start, muldiv_done, mem_busy, ex_is_fencei;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, fencei_redirect;
`ifdef YSYX_22050598_HAZ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  always #5 clk = ~clk;
  ysyx_22050598_pipe_ctrl #(.FENCEI_CYCLES(FC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_rd_idx(ex_rd_idx), .ex_w_reg_en(ex_w_reg_en), .ex_ls_req(ex_ls_req), .ex_is_store(ex_is_store),
    .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start), .muldiv_done(muldiv_done),
    .mem_busy(mem_busy), .ex_is_fencei(ex_is_fencei),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .fencei_redirect(fencei_redirect)
`ifdef YSYX_22050598_HAZ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic [31:0] pst_q[$], pfl_q[$];
  bit          pv_q[$];
  int errors = 0, checks = 0;
  bit in_muldiv = 0;
  int drain_left = 0;
  logic [31:0] m_pst, m_pfl;
  bit perf_known = 0;
  // Expected outputs packed as {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, fencei_redirect}
  task automatic apply(input stim_t s, input string nm);
    logic [7:0] e;
    bit hz;
    @(posedge clk);
    #1;
    {rst, id_rs1_idx, id_rs2_idx, id_rs1_ren, id_rs2_ren, ex_rd_idx, ex_w_reg_en, ex_ls_req, ex_is_store,
     ex_redirect, ex_muldiv_start, muldiv_done, mem_busy, ex_is_fencei} = s;
    hz = s.ls && !s.st && s.wen && s.rd != 0 && ((s.ren1 && s.rs1 == s.rd) || (s.ren2 && s.rs2 == s.rd));
    e = 8'h00;
    if (s.rst) begin
      in_muldiv = 0;
      drain_left = 0;
    end else if (s.busy) e = 8'b1101_0100;
    else if (in_muldiv) begin
      if (s.mdd) in_muldiv = 0;
      else e = 8'b1101_0010;
    end else if (drain_left > 0) begin
      e = (drain_left == 1) ? 8'b1010_1001 : 8'b1010_1000;
      drain_left--;
    end else if (s.redir) e = 8'b0010_1000;
    else if (s.fi) begin
      e = 8'b1010_0000;
      drain_left = FC;
    end else if (s.mds) begin
      if (!s.mdd) begin
        e = 8'b1101_0010;
        in_muldiv = 1;
      end
    end else if (hz) e = 8'b1100_1000;
    exp_q.push_back(e);
    name_q.push_back(nm);
    pst_q.push_back(m_pst);
    pfl_q.push_back(m_pfl);
    pv_q.push_back(perf_known);
    if (s.rst) begin
      m_pst = 0;
      m_pfl = 0;
      perf_known = 1;
    end else begin
      m_pst = m_pst + 32'(e[7]);
      m_pfl = m_pfl + 32'(e[3]);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] got, e;
      string nm;
      logic [31:0] ps, pf;
      bit pv;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      ps = pst_q.pop_front();
      pf = pfl_q.pop_front();
      pv = pv_q.pop_front();
      got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, fencei_redirect};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: outputs got %b want %b at %0t", nm, got, e, $time);
      end
`ifdef YSYX_22050598_HAZ_PERF_EN
      if (pv) begin
        checks++;
        if (perf_stall_cnt !== ps || perf_flush_cnt !== pf) begin
          errors++;
          $display("FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d", nm,
                   perf_stall_cnt, perf_flush_cnt, ps, pf);
        end
      end
`else
      if (pv && ps == 32'hffff_ffff && pf == 32'hffff_ffff) $display("note: perf model saturated");
`endif
    end
  end
  initial begin
    stim_t z, lu, s;
    {rst, id_rs1_idx, id_rs2_idx, id_rs1_ren, id_rs2_ren, ex_rd_idx, ex_w_reg_en, ex_ls_req, ex_is_store,
     ex_redirect, ex_muldiv_start, muldiv_done, mem_busy, ex_is_fencei} = '0;
    z = '0;
    lu = '0;
    lu.ls = 1; lu.wen = 1; lu.rd = 5; lu.rs1 = 5; lu.ren1 = 1;
    s = z; s.rst = 1;
    apply(s, "reset0");
    apply(s, "reset1");
    apply(lu, "load_use");
    apply(z, "load_use_bubble");
    s = lu; s.rd = 0; s.rs1 = 0;
    apply(s, "rd_zero");
    s = lu; s.st = 1;
    apply(s, "store");
    s = lu; s.ren1 = 0; s.rs2 = 5; s.ren2 = 1;
    apply(s, "load_use_rs2");
    s = lu; s.redir = 1;
    apply(s, "redirect_beats_hazard");
    apply(lu, "load_use2");
    s = z; s.redir = 1;
    apply(s, "redirect2");
    apply(lu, "load_use3");
    s = z; s.mds = 1;
    apply(s, "muldiv_start");
    repeat (4) apply(z, "muldiv_wait");
    s = z; s.mdd = 1;
    apply(s, "muldiv_done");
    apply(z, "after_muldiv");
    s = z; s.mds = 1;
    apply(s, "muldiv_start_b");
    apply(z, "muldiv_wait_b");
    s = z; s.busy = 1;
    apply(s, "muldiv_mem_busy");
    repeat (4) apply(z, "muldiv_wait_b");
    s = z; s.mdd = 1;
    apply(s, "muldiv_done_b");
    s = z; s.mds = 1; s.mdd = 1;
    apply(s, "muldiv_same_cycle_done");
    s = z; s.fi = 1;
    apply(s, "fencei_start");
    repeat (4) apply(z, "fencei_drain");
    apply(z, "after_fencei");
    s = z; s.fi = 1;
    apply(s, "fencei_start_r");
    apply(z, "fencei_drain_r");
    s = z; s.rst = 1;
    apply(s, "fencei_reset");
    repeat (5) apply(z, "after_fencei_reset");
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(99) < 2);
      s.rs1   = 5'($urandom_range(3));
      s.rs2   = 5'($urandom_range(3));
      s.ren1  = 1'($urandom);
      s.ren2  = 1'($urandom);
      s.rd    = 5'($urandom_range(3));
      s.wen   = ($urandom_range(99) < 70);
      s.ls    = ($urandom_range(99) < 50);
      s.st    = ($urandom_range(99) < 25);
      s.redir = ($urandom_range(99) < 10);
      s.mds   = ($urandom_range(99) < 10);
      s.mdd   = ($urandom_range(99) < 30);
      s.busy  = ($urandom_range(99) < 15);
      s.fi    = ($urandom_range(99) < 5);
      apply(s, "random");
    end
    apply(z, "final_idle");
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050598_pipe_ctrl.md
Name: ysyx_22050598_pipe_ctrl

Overview:
Central hazard/pipeline controller that drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC hold. It is the producing end of the stall/flush interface consumed by the inter-stage dfflr registers:
- detects load-use hazards and inserts bubbles;
- squashes wrong-path instructions on EX redirects;
- holds the pipe for multi-cycle mul/div, LSU waits and fence.i drain.

Parameters:
FENCEI_CYCLES, 4, drain length of fence.i in cycles (>=1)
CNT_W, 3, width of drain counter; must satisfy 2^CNT_W > FENCEI_CYCLES

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
id_rs1_idx  input  5  rs1 index of instruction in ID
id_rs2_idx  input  5  rs2 index of instruction in ID
id_rs1_ren  input  1  ID reads rs1
id_rs2_ren  input  1  ID reads rs2
ex_rd_idx  input  5  rd of instruction in EX
ex_w_reg_en  input  1  EX instruction writes rd
ex_ls_req  input  1  EX instruction is load/store
ex_is_store  input  1  EX instruction is store
ex_redirect  input  1  taken branch / jal / jalr / mret / ecall resolved in EX (1-cycle pulse)
ex_muldiv_start  input  1  EX issues mul/div to multi-cycle unit
muldiv_done  input  1  mul/div result valid
mem_busy  input  1  LSU waiting on bus
ex_is_fencei  input  1  fence.i in EX
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  squash IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  insert bubble into ID/EX
ex_mem_stall  output  1  hold EX/MEM
ex_mem_flush  output  1  insert bubble into EX/MEM
fencei_redirect  output  1  1-cycle pulse: refetch from pc+4 after drain

Behaviour:
- Reset:
  - While rst=1, every output is 0, state=IDLE, drain counter=0.
  - rst asserted mid-operation aborts MULDIV_WAIT or FENCEI_DRAIN on the next edge; no pulse is emitted.
- Registered state is {IDLE, MULDIV_WAIT, FENCEI_DRAIN} plus the drain counter. Outputs are combinational from state and inputs (0-cycle latency).
- Priority, highest first:
  - P1, mem_busy=1, any state: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1; every flush is 0. State and counter are frozen; every other event is ignored that cycle.
  - P2, MULDIV_WAIT: pc_stall, if_id_stall and id_ex_stall are 1; ex_mem_flush=1 (bubble into MEM). On muldiv_done=1, outputs are all 0 that cycle and the next state is IDLE. ex_redirect, ex_is_fencei and the load-use hazard are ignored.
  - P3, FENCEI_DRAIN: pc_stall=1, if_id_flush=1, id_ex_flush=1. Counter decrements each cycle. In the cycle where counter==0, fencei_redirect=1 and the next state is IDLE.
  - P4, IDLE with ex_redirect=1: if_id_flush=1 and id_ex_flush=1; PC is not stalled. Overrides the load-use hazard, because the ID instruction is wrong-path.
  - P5, IDLE with ex_is_fencei=1: load counter=FENCEI_CYCLES-1, go to FENCEI_DRAIN. Outputs this cycle: pc_stall=1, if_id_flush=1.
  - P6, IDLE with ex_muldiv_start=1: go to MULDIV_WAIT. Outputs this cycle are the MULDIV_WAIT set. If muldiv_done=1 in the same cycle, stay IDLE with no stall.
  - P7, IDLE load-use: the hazard is ex_ls_req & ~ex_is_store & ex_w_reg_en & (ex_rd_idx!=0) & ((id_rs1_ren & id_rs1_idx==ex_rd_idx) | (id_rs2_ren & id_rs2_idx==ex_rd_idx)). Response: pc_stall=1, if_id_stall=1, id_ex_flush=1, for exactly one cycle per hazard.
  - P8, otherwise all outputs are 0.
- Invariant: a stall and a flush are never both asserted for the same register.
- Counter never wraps; FENCEI_CYCLES=1 gives a single drain cycle with the immediate redirect pulse.

Optional Feature:
YSYX_22050598_HAZ_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both cleared by rst.
  - perf_stall_cnt increments every cycle pc_stall=1.
  - perf_flush_cnt increments every cycle id_ex_flush=1.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex = lw x5 (ls_req=1, store=0, w_en=1, rd=5); id rs1=5, rs1_ren=1 -> 1 cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (EX now bubble) all outputs 0.
- rd=0 / store: same stimulus with rd=0, or with ex_is_store=1 -> no stall.
- Redirect beats hazard: load-use condition together with ex_redirect=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
- Mul/div: ex_muldiv_start pulse, then muldiv_done raised 5 cycles later -> pc/if_id/id_ex stall and ex_mem_flush high for 5 cycles, all 0 on the done cycle. A mem_busy pulse mid-wait adds ex_mem_stall=1 and ex_mem_flush=0 for that cycle, and the wait is extended by that cycle.
- fence.i, FENCEI_CYCLES=4: ex_is_fencei pulse -> pc_stall high 5 cycles; fencei_redirect=1 only in the 5th; state IDLE after. rst asserted in the 3rd drain cycle -> outputs 0 and no pulse.
- Perf (macro on): 3 load-use hazards + 2 redirects -> perf_stall_cnt=3, perf_flush_cnt=5.
